command_register_load: RTL and testbench
========================================

// Module: command_register_load
// PURPOSE
// - Consumes the G15 timing strobes (CL, T0, T29) and loads one 29-bit command
//   word from the serial drum read line into the command register when RC is asserted.
// - Sits between the timing generator and the control decode logic.
// - Presents decoded command fields plus a one-cycle cmd_valid pulse.
// PARAMETERS
// - WORD_BITS  29  serial bits per word, bit times T1..T29; T0 is the gap bit
// - CNT_W      5   bit-counter width; must satisfy 2**CNT_W > WORD_BITS
// PORTS
// - clk        in   1   system clock; all logic rising-edge
// - rst        in   1   asynchronous, active-high reset
// - CL         in   1   G15 bit-time strobe, one clk cycle wide per bit time
// - T0         in   1   high during bit time 0 (word gap)
// - T29        in   1   high during last bit time of word
// - RC         in   1   read-command gate (level)
// - rd_bit     in   1   serial read-line data, valid when CL high
// - cmd_valid  out  1   one-cycle pulse: new command loaded
// - frame_err  out  1   sticky; set on framing error, cleared by rst or next RC rise
// - busy       out  1   high in ARMED or SHIFT
// - cmd_word   out  29  full command word; bit 0 = first bit received (T1)
// - cmd_dbl    out  1   cmd_word[0]   single/double precision
// - cmd_src    out  5   cmd_word[5:1]
// - cmd_dst    out  5   cmd_word[10:6]
// - cmd_chr    out  2   cmd_word[12:11] characteristic
// - cmd_next   out  7   cmd_word[19:13] next command location
// - cmd_bp     out  1   cmd_word[20] breakpoint flag
// - cmd_t      out  7   cmd_word[27:21] timing number
// - cmd_imm    out  1   cmd_word[28] immediate/deferred
// - halt_req   out  1   see CONFIGURATION
// BEHAVIOUR
// - Reset: state IDLE, counter 0, shift reg 0, cmd_word 0, all outputs 0.
// - Field outputs are slices of cmd_word (registered); update only on load.
// - RC edge detect: registered rc_q; arm on RC & ~rc_q. One load per RC assertion;
//   RC must drop and rise again to rearm. RC rise also clears frame_err.
// - FSM:
//   IDLE  : RC rise -> ARMED.
//   ARMED : CL & T0 -> SHIFT, counter <= 0. RC low -> IDLE (no valid).
//   SHIFT : on CL: shift rd_bit into bit[counter], counter++.
//           CL & T29 with counter == WORD_BITS-1 -> cmd_word <= assembled word,
//             cmd_valid = 1 next cycle, -> DONE.
//           CL & T29 with counter != WORD_BITS-1 -> frame_err=1, -> IDLE.
//           CL & T0 (gap during shift) -> frame_err=1, -> IDLE.
//           RC low -> IDLE, abort silently, cmd_word unchanged.
//   DONE  : single cycle; -> IDLE. busy low.
// - Latency: cmd_valid asserts exactly 1 clk after the CL cycle carrying T29.
// - Cycles with CL low never shift or change state (except RC-low abort).
// - RC rise while not IDLE: ignored (no restart).
// - Async rst mid-SHIFT: partial word discarded, cmd_word cleared to 0.
// CONFIGURATION
// - Macro CMD_REG_BREAKPOINT_EN.
// - Defined: halt_req set 1 clk with cmd_valid when loaded cmd_bp = 1; sticky
//   until rst or next RC rise.
// - Not defined: halt_req tied 0; cmd_bp still reported.
// TESTING
// - Load: RC rise, T0 then 29 CL bits of 29'h0ABCDEF1 LSB first -> cmd_valid once
//   1 clk after T29 strobe, cmd_word=29'h0ABCDEF1, fields match slices.
// - RC held high across 3 word times -> exactly one cmd_valid; drop/raise RC -> second load.
// - RC dropped after 10 bits -> no cmd_valid, cmd_word keeps prior value, busy=0.
// - T29 injected at bit 15 -> frame_err=1, state IDLE; next RC rise clears it.
// - rst pulsed mid-SHIFT -> all outputs 0 immediately; clean load afterwards.
// - CMD_REG_BREAKPOINT_EN defined, word with bit 20 set -> halt_req=1 with
//   cmd_valid; macro undefined -> halt_req stays 0.

Source files
------------

// File: rtl/command_register_load.sv
// G15 command register: loads one 29-bit serial command word per RC assertion and presents decoded fields.
// Optional macro CMD_REG_BREAKPOINT_EN enables a sticky halt_req raised when a loaded word has its breakpoint bit set.
module command_register_load #(
   parameter int WORD_BITS = 29,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 CL,
   input  logic                 T0,
   input  logic                 T29,
   input  logic                 RC,
   input  logic                 rd_bit,
   output logic                 cmd_valid,
   output logic                 frame_err,
   output logic                 busy,
   output logic [WORD_BITS-1:0] cmd_word,
   output logic                 cmd_dbl,
   output logic [4:0]           cmd_src,
   output logic [4:0]           cmd_dst,
   output logic [1:0]           cmd_chr,
   output logic [6:0]           cmd_next,
   output logic                 cmd_bp,
   output logic [6:0]           cmd_t,
   output logic                 cmd_imm,
   output logic                 halt_req
);

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
   localparam int               BP_BIT   = 20;

   // state is left as a named register so checkers can bind to it directly
   state_t                 state;
   logic                   rc_q;
   logic [CNT_W-1:0]       cnt;
   logic [WORD_BITS-1:0]   sreg;
   logic [WORD_BITS-1:0]   sreg_next;
   logic                   rc_rise;
   logic                   load;

   assign rc_rise = RC & ~rc_q;

   always_comb begin
      sreg_next = sreg;
      if (cnt <= LAST_BIT)
         sreg_next[cnt] = rd_bit;
   end

   // A word is accepted only when T29 arrives on exactly the last bit slot
   assign load = (state == SHIFT) && RC && CL && T29 && (cnt == LAST_BIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rc_q      <= 1'b0;
         cnt       <= '0;
         sreg      <= '0;
         cmd_word  <= '0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rc_q      <= RC;
         cmd_valid <= 1'b0;
         if (rc_rise)
            frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rc_rise) begin
                  state <= ARMED;
                  busy  <= 1'b1;
               end
            end
            ARMED: begin
               if (!RC) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (CL && T0) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  sreg  <= '0;
               end
            end
            SHIFT: begin
               if (!RC) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (CL) begin
                  sreg <= sreg_next;
                  cnt  <= cnt + 1'b1;
                  if (load) begin
                     cmd_word  <= sreg_next;
                     cmd_valid <= 1'b1;
                     state     <= DONE;
                     busy      <= 1'b0;
                  end else if (T29 || T0) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CMD_REG_BREAKPOINT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         halt_req <= 1'b0;
      else if (load && sreg_next[BP_BIT])
         halt_req <= 1'b1;
      else if (rc_rise)
         halt_req <= 1'b0;
   end
`else
   assign halt_req = 1'b0;
`endif

   assign cmd_dbl  = cmd_word[0];
   assign cmd_src  = cmd_word[5:1];
   assign cmd_dst  = cmd_word[10:6];
   assign cmd_chr  = cmd_word[12:11];
   assign cmd_next = cmd_word[19:13];
   assign cmd_bp   = cmd_word[BP_BIT];
   assign cmd_t    = cmd_word[27:21];
   assign cmd_imm  = cmd_word[28];

endmodule

// File: tb/tb_command_register_load.sv
// Bench for command_register_load: directed scenarios with random words and random CL spacing.
// Honours CMD_REG_BREAKPOINT_EN when deciding whether halt_req is expected.
module tb_command_register_load;

   logic        clk = 1'b0;
   logic        rst, CL, T0, T29, RC, rd_bit;
   logic        cmd_valid, frame_err, busy;
   logic [28:0] cmd_word;
   logic        cmd_dbl;
   logic [4:0]  cmd_src, cmd_dst;
   logic [1:0]  cmd_chr;
   logic [6:0]  cmd_next;
   logic        cmd_bp;
   logic [6:0]  cmd_t;
   logic        cmd_imm;
   logic        halt_req;

   int n_tests   = 0;
   int n_fail    = 0;
   int valid_cnt = 0;

   // reference state: what the register should hold after each scenario
   logic [28:0] exp_word;
   logic        exp_halt;
   logic        bp_en;

   command_register_load dut (
      .clk(clk), .rst(rst), .CL(CL), .T0(T0), .T29(T29), .RC(RC), .rd_bit(rd_bit),
      .cmd_valid(cmd_valid), .frame_err(frame_err), .busy(busy), .cmd_word(cmd_word),
      .cmd_dbl(cmd_dbl), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_chr(cmd_chr),
      .cmd_next(cmd_next), .cmd_bp(cmd_bp), .cmd_t(cmd_t), .cmd_imm(cmd_imm),
      .halt_req(halt_req)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (cmd_valid === 1'b1) valid_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cl, input logic t0, input logic t29, input logic b);
      CL = cl; T0 = t0; T29 = t29; rd_bit = b;
      tick();
   endtask

   task automatic rc_restart();
      RC = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      RC = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      exp_halt = 1'b0;
   endtask

   // Gap bit then 29 data bits LSB first; bad_* / drop_at inject a fault at that bit slot.
   task automatic send_frame(input logic [28:0] w, input int bad_t29, input int bad_t0, input int drop_at);
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      drive(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 29; i++) begin
         repeat ($urandom_range(0, 1)) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         if (i == drop_at) begin
            RC = 1'b0;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
         if (i == bad_t0) begin
            drive(1'b1, 1'b1, 1'b0, w[i]);
            return;
         end
         drive(1'b1, 1'b0, (i == 28) || (i == bad_t29), w[i]);
         if (i == bad_t29) return;
      end
   endtask

   task automatic check_fields(input string tag, input logic [28:0] w);
      check({tag, "_word"}, 32'(cmd_word), 32'(w));
      check({tag, "_dbl"},  32'(cmd_dbl),  32'(w[0]));
      check({tag, "_src"},  32'(cmd_src),  32'(w[5:1]));
      check({tag, "_dst"},  32'(cmd_dst),  32'(w[10:6]));
      check({tag, "_chr"},  32'(cmd_chr),  32'(w[12:11]));
      check({tag, "_next"}, 32'(cmd_next), 32'(w[19:13]));
      check({tag, "_bp"},   32'(cmd_bp),   32'(w[20]));
      check({tag, "_t"},    32'(cmd_t),    32'(w[27:21]));
      check({tag, "_imm"},  32'(cmd_imm),  32'(w[28]));
   endtask

   // Full good load: one pulse, right after the T29 edge, then gone.
   task automatic good_load(input string tag, input logic [28:0] w);
      int v0;
      rc_restart();
      check({tag, "_busy_armed"}, 32'(busy), 32'd1);
      v0 = valid_cnt;
      send_frame(w, 99, 99, 99);
      exp_word = w;
      exp_halt = bp_en & w[20];
      check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check_fields(tag, w);
      check({tag, "_halt"}, 32'(halt_req), 32'(exp_halt));
      tick();
      check({tag, "_valid_drop"}, 32'(cmd_valid), 32'd0);
      check({tag, "_halt_sticky"}, 32'(halt_req), 32'(exp_halt));
      check({tag, "_pulses"}, 32'(valid_cnt - v0), 32'd1);
   endtask

   initial begin
      int v0;
      logic [28:0] w;
`ifdef CMD_REG_BREAKPOINT_EN
      bp_en = 1'b1;
`else
      bp_en = 1'b0;
`endif
      rst = 1'b1; RC = 1'b0; CL = 1'b0; T0 = 1'b0; T29 = 1'b0; rd_bit = 1'b0;
      exp_word = '0; exp_halt = 1'b0;
      tick(); tick();
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_err",   32'(frame_err), 32'd0);
      check("rst_word",  32'(cmd_word),  32'd0);
      check("rst_halt",  32'(halt_req),  32'd0);
      rst = 1'b0;
      tick();

      // known word has bit 20 set
      good_load("load_abc", 29'h0ABCDEF1);

      // RC held high across further words: nothing reloads
      v0 = valid_cnt;
      send_frame(29'($urandom), 99, 99, 99);
      send_frame(29'($urandom), 99, 99, 99);
      check("held_pulses", 32'(valid_cnt - v0), 32'd0);
      check("held_word", 32'(cmd_word), 32'(exp_word));
      check("held_busy", 32'(busy), 32'd0);

      w = 29'($urandom);
      w[20] = 1'b0;
      good_load("reload_nobp", w);
      for (int k = 0; k < 4; k++) good_load("rand_load", 29'($urandom));

      // RC dropped mid-word: silent abort
      rc_restart();
      v0 = valid_cnt;
      send_frame(29'($urandom), 99, 99, 10);
      check("drop_pulses", 32'(valid_cnt - v0), 32'd0);
      check("drop_word", 32'(cmd_word), 32'(exp_word));
      check("drop_busy", 32'(busy), 32'd0);
      check("drop_err", 32'(frame_err), 32'd0);

      // early T29 is a framing error
      rc_restart();
      v0 = valid_cnt;
      send_frame(29'($urandom), 15, 99, 99);
      check("t29_err", 32'(frame_err), 32'd1);
      check("t29_busy", 32'(busy), 32'd0);
      check("t29_word", 32'(cmd_word), 32'(exp_word));
      tick(); tick();
      check("t29_err_sticky", 32'(frame_err), 32'd1);
      check("t29_pulses", 32'(valid_cnt - v0), 32'd0);
      rc_restart();
      check("t29_err_clr", 32'(frame_err), 32'd0);
      RC = 1'b0;
      good_load("after_err", 29'($urandom));

      // gap bit during shift is a framing error
      rc_restart();
      send_frame(29'($urandom), 99, 7, 99);
      check("t0_err", 32'(frame_err), 32'd1);
      check("t0_busy", 32'(busy), 32'd0);
      check("t0_word", 32'(cmd_word), 32'(exp_word));

      // async reset in the middle of a word
      rc_restart();
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #2;
      check("arst_word",  32'(cmd_word),  32'd0);
      check("arst_busy",  32'(busy),      32'd0);
      check("arst_err",   32'(frame_err), 32'd0);
      check("arst_valid", 32'(cmd_valid), 32'd0);
      check("arst_halt",  32'(halt_req),  32'd0);
      RC = 1'b0;
      tick();
      rst = 1'b0;
      exp_word = '0;
      exp_halt = 1'b0;
      tick();
      w = 29'($urandom);
      w[20] = 1'b1;
      good_load("post_rst", w);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
